// File: rtl/palindrome_pkg.sv
// Shared types for the palindrome arbiter: controller state encoding.
package palindrome_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/palindrome_core.sv
// Combinational palindrome detector: the word must equal its own bit reversal.
module palindrome_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  output logic                  pal
);

  logic [DATA_WIDTH-1:0] reversed;

  // Comparing against the full reversal covers odd widths (middle bit meets itself) and width 1.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_rev
    assign reversed[gi] = word[DATA_WIDTH-1-gi];
  end

  assign pal = (reversed == word);

endmodule

// File: rtl/palindrome_arbiter.sv
// Round-robin arbiter feeding a shared palindrome detector; one result in flight at a time.
module palindrome_arbiter
  import palindrome_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REQ    = 4,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_pal,
  output logic                          busy
);

  state_t                state_reg;
  state_t                state_next;
  logic [ID_W-1:0]       last_grant_reg;
  logic [DATA_WIDTH-1:0] word_reg;
  logic [ID_W-1:0]       id_reg;
  logic                  pal_reg;
  logic [ID_W-1:0]       rsp_id_reg;

  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic                  accept;
  logic                  core_pal;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found &&
          req_valid[ID_W'((int'(last_grant_reg) + k) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'((int'(last_grant_reg) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
          state_next          = EVAL;
        end
      end
      EVAL:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      word_reg       <= '0;
      id_reg         <= '0;
      pal_reg        <= 1'b0;
      rsp_id_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        last_grant_reg <= grant_id;
        word_reg       <= req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        id_reg         <= grant_id;
      end
      // Result fields are zero outside RESP, so they are cleared as the response retires.
      if (state_reg == EVAL) begin
        pal_reg    <= core_pal;
        rsp_id_reg <= id_reg;
      end else if (state_reg == RESP && rsp_ready) begin
        pal_reg    <= 1'b0;
        rsp_id_reg <= '0;
      end
    end
  end

  palindrome_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .word(word_reg),
    .pal (core_pal)
  );

  assign rsp_valid = (state_reg == RESP);
  assign rsp_pal   = pal_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: doc/palindrome_arbiter.md
PALINDROME_ARBITER -- requirements
Module: palindrome_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bit width of each candidate word (odd or even, >=1).
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one detector (>=2); ID_W = $clog2(NUM_REQ).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester word-valid.
REQ-006 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, requester i word at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_ready, output, NUM_REQ, one-hot-or-zero grant; request i is accepted when req_valid[i] & req_ready[i].
REQ-008 SHALL have port rsp_valid, output, 1, result available.
REQ-009 SHALL have port rsp_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have port rsp_id, output, ID_W, index of the requester the result belongs to.
REQ-011 SHALL have port rsp_pal, output, 1, 1 when the word reads identically from bit 0 up and from bit DATA_WIDTH-1 down.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the states IDLE, EVAL and RESP.
REQ-014 In IDLE with any req_valid set, the block SHALL assert req_ready combinationally for exactly one winner, then latch that winner's word and index and enter EVAL.
REQ-015 In IDLE with no req_valid set, req_ready SHALL be all zero and the state SHALL remain IDLE.
REQ-016 Winner selection SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ, increasing with wrap, and the first set req_valid wins.
REQ-017 last_grant SHALL update to the winner index on each accepted request.
REQ-018 req_ready SHALL be all zero in EVAL and RESP, so no request is accepted while a result is outstanding.
REQ-019 In EVAL, the block SHALL evaluate the latched word through the detector, register rsp_pal and rsp_id, and enter RESP; EVAL lasts exactly one cycle.
REQ-020 The palindrome rule SHALL be: for every i < DATA_WIDTH/2 (integer division), bit i equals bit DATA_WIDTH-1-i; for odd widths the middle bit is unconstrained; DATA_WIDTH=1 always yields 1.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_id and rsp_pal SHALL hold stable until rsp_ready is sampled high; the block then enters IDLE.
REQ-022 Latency SHALL be fixed: acceptance in cycle T gives rsp_valid=1 in cycle T+2; minimum spacing between acceptances is 3 cycles.
REQ-023 Whenever rsp_valid=0, rsp_pal and rsp_id SHALL be held at 0.
REQ-024 Changes to req_valid or req_data after acceptance SHALL NOT affect the result in flight.

Reset
REQ-025 While resetn=0, independent of clk, the block SHALL force: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), latched word=0, rsp_valid=0, rsp_id=0, rsp_pal=0, busy=0.
REQ-026 Reset asserted during EVAL or RESP SHALL abort the in-flight result with no response emitted.
REQ-027 After resetn deasserts, the first arbitration SHALL occur on the first rising edge.

Structure
REQ-028 Package palindrome_pkg SHALL hold the state enum (IDLE, EVAL, RESP).
REQ-029 The palindrome check SHALL be a combinational sub-module palindrome_core, parameterised by DATA_WIDTH, with a single instance.
REQ-030 Arbitration SHALL stay inline; no further sub-modules.

Verification (DATA_WIDTH=8, NUM_REQ=4 unless noted)
REQ-031 req_valid=0001, req_data[0]=8'b10011001, rsp_ready=1 -> req_ready=0001 in cycle T; rsp_valid at T+2 with rsp_id=0, rsp_pal=1.
REQ-032 req_valid=1111 held, words 8'hA5, 8'h81, 8'h3C, 8'h01 -> grants in order 0,1,2,3,0 at 3-cycle spacing; rsp_pal sequence 1,1,1,0,1.
REQ-033 Single accepted request, rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id and rsp_pal stable for 5 cycles, req_ready=0000, busy=1; IDLE the cycle after rsp_ready=1.
REQ-034 resetn pulsed low during EVAL -> all outputs 0 immediately; no rsp_valid afterwards; next grant with req_valid=1111 goes to requester 0.
REQ-035 DATA_WIDTH=7: 7'b1010101 -> rsp_pal=1; 7'b1011101 -> rsp_pal=1 (middle bit ignored); 7'b1010100 -> rsp_pal=0.
REQ-036 req_data[0] changed from 8'hFF to 8'h01 in cycle T+1 after acceptance of 8'hFF -> rsp_pal=1.
